// File: rtl/mult_div_pkg.sv
// Shared types and constants for the mult/div sequencer.
package mult_div_pkg;

  localparam int unsigned DefWidth = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CntWidth = cnt_width(DefWidth);

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StDiv,
    StFix
  } md_state_e;

endpackage

// File: rtl/md_iter_unit.sv
// Radix-2 iteration datapath: one shift-add (multiply) or restore-subtract (divide) step per
// enable, over a 2*Width accumulator whose upper half is the partial product / remainder.
module md_iter_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [Width-1:0]   op_a_i,
  input  logic [Width-1:0]   op_b_i,
  output logic [2*Width-1:0] acc_o
);

  logic [2*Width-1:0] acc_q, acc_d;
  logic [Width-1:0]   opb_q, opb_d;
  logic [Width-1:0]   hi_part;
  logic [Width-1:0]   rem_next;
  logic [Width:0]     add_sum;
  logic [Width:0]     sub_trial;

  assign hi_part = acc_q[2*Width-1:Width];
  assign acc_o   = acc_q;

  always_comb begin
    acc_d     = acc_q;
    opb_d     = opb_q;
    add_sum   = {1'b0, hi_part} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Trial subtract on the remainder shifted left by one; a borrow means restore.
    sub_trial = {hi_part, acc_q[Width-1]} - {1'b0, opb_q};
    rem_next  = sub_trial[Width] ? {hi_part[Width-2:0], acc_q[Width-1]} : sub_trial[Width-1:0];
    if (load_i) begin
      acc_d = {{Width{1'b0}}, op_a_i};
      opb_d = op_b_i;
    end else if (step_i) begin
      if (div_i) begin
        acc_d = {rem_next, acc_q[Width-2:0], ~sub_trial[Width]};
      end else begin
        acc_d = {add_sum, acc_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle sequencer for MIPS mult/div owning HI/LO.
// Optional MULT_DIV_UNSIGNED_EN adds is_unsigned for multu/divu.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  md_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               is_div_q, is_div_d;
  logic               signed_op;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               iter_load, iter_step;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  assign neg_a_in = signed_op & a_in[WIDTH-1];
  assign neg_b_in = signed_op & b_in[WIDTH-1];
  assign mag_a    = neg_a_in ? -a_in : a_in;
  assign mag_b    = neg_b_in ? -b_in : b_in;

  // Quotient sign follows the operand signs, remainder follows the dividend.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc : acc;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    is_div_d   = is_div_q;
    iter_load  = 1'b0;
    iter_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_mult || start_div) begin
          div_zero_d = 1'b0;
          neg_a_d    = neg_a_in;
          neg_b_d    = neg_b_in;
          is_div_d   = ~start_mult;
          cnt_d      = '0;
          iter_load  = 1'b1;
          if (start_mult) begin
            state_d = StMult;
          end else if (b_in == '0) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StMult, StDiv: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
          cnt_d   = '0;
        end
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      is_div_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      is_div_q   <= is_div_d;
    end
  end

  md_iter_unit #(
    .Width (WIDTH)
  ) u_iter (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (iter_load),
    .step_i (iter_step),
    .div_i  (state_q == StDiv),
    .op_a_i (mag_a),
    .op_b_i (mag_b),
    .acc_o  (acc)
  );

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed corner cases plus randomized ops
// checked against a plain-arithmetic signed mult/div model.
module tb_mult_div_ctrl;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_mult, start_div;
  logic [W-1:0]  a_in, b_in;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi_out, lo_out;

  int            n_vec = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_hi, exp_lo;
  logic          exp_dz;

  always #5 clk = ~clk;

  mult_div_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed product, C-style truncating divide.
  task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_div) begin
      p      = longint'(sa) * longint'(sb);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dz = 1'b0;
    end else if (b == 32'd0) begin
      exp_dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exp_lo = 32'h8000_0000;
      exp_hi = 32'd0;
      exp_dz = 1'b0;
    end else begin
      q      = sa / sb;
      r      = sa % sb;
      exp_lo = q;
      exp_hi = r;
      exp_dz = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input bit is_div, input bit both, input bit poke,
                        input logic [31:0] a, input logic [31:0] b);
    int edges;
    int busy_low;
    int extra;
    @(negedge clk);
    start_mult = !is_div || both;
    start_div  = is_div || both;
    a_in       = a;
    b_in       = b;
    model(is_div && !both, a, b);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a_in       = $urandom;
    b_in       = $urandom;
    @(negedge clk);
    if (is_div && !both && b == 32'd0) begin
      check_eq("dz_done", 32'(done), 32'd1);
      check_eq("dz_flag", 32'(div_zero), 32'd1);
      check_eq("dz_busy", 32'(busy), 32'd0);
      check_eq("dz_hi", hi_out, exp_hi);
      check_eq("dz_lo", lo_out, exp_lo);
      @(negedge clk);
      check_eq("dz_done_pulse", 32'(done), 32'd0);
      check_eq("dz_flag_hold", 32'(div_zero), 32'd1);
      return;
    end
    check_eq("accept_dz_clr", 32'(div_zero), 32'd0);
    edges    = 0;
    busy_low = 0;
    while (!done && edges < 200) begin
      if (!busy) busy_low++;
      if (poke) begin
        start_div  = (edges == 5);
        start_mult = (edges == 7);
        b_in       = 32'd0;
      end
      @(negedge clk);
      edges++;
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    check_eq("latency", 32'(edges), 32'(W + 1));
    check_eq("busy_in_flight", 32'(busy_low), 32'd0);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("hi", hi_out, exp_hi);
    check_eq("lo", lo_out, exp_lo);
    check_eq("div_zero", 32'(div_zero), 32'(exp_dz));
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    if (poke) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check_eq("busy_start_ignored", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int late;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a_in       = '0;
    b_in       = '0;
    exp_hi     = '0;
    exp_lo     = '0;
    exp_dz     = 1'b0;
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dz", 32'(div_zero), 32'd0);
    check_eq("rst_hi", hi_out, 32'd0);
    check_eq("rst_lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
    check_eq("plan_mult_hi", hi_out, 32'hFFFF_FFFF);
    check_eq("plan_mult_lo", lo_out, 32'hFFFF_FFEB);
    run_op(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    check_eq("plan_div_lo", lo_out, 32'd14);
    check_eq("plan_div_hi", hi_out, 32'd2);
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
    check_eq("plan_ndiv_lo", lo_out, 32'hFFFF_FFFD);
    check_eq("plan_ndiv_hi", hi_out, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 1'b0, 32'd55, 32'd0);
    run_op(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("plan_ovf_lo", lo_out, 32'h8000_0000);
    check_eq("plan_ovf_hi", hi_out, 32'd0);
    run_op(1'b0, 1'b1, 1'b0, 32'd6, 32'hFFFF_FFFB);
    run_op(1'b0, 1'b0, 1'b1, 32'd123456, 32'd654321);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start_mult = 1'b1;
    a_in       = 32'd99;
    b_in       = 32'd77;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_hi", hi_out, 32'd0);
    check_eq("midrst_lo", lo_out, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    late  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) late++;
    end
    check_eq("midrst_no_done", 32'(late), 32'd0);
    run_op(1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
    check_eq("restart_lo", lo_out, 32'd12);
    check_eq("restart_hi", hi_out, 32'd0);

    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom_range(0, 1)), 1'b0, 1'b0, pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multicycle sequencer for the MIPS mult/div instructions (signed `mult`, `div`).
- Owns the HI/LO registers and runs a radix-2 shift-add multiplier or restoring divider over WIDTH iterations.
- Sits beside the ALU. The main Control FSM pulses a start, waits on busy/done, then reads hi_out/lo_out for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; also the number of iterations.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_mult  in  1  one-cycle request: signed multiply of a_in by b_in.
- start_div  in  1  one-cycle request: signed divide, a_in / b_in.
- a_in  in  WIDTH  operand A (register A output); sampled only on the accepting edge.
- b_in  in  WIDTH  operand B (register B output); sampled only on the accepting edge.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi_out/lo_out are valid from this cycle.
- div_zero  out  1  previous divide had b_in==0.
- hi_out  out  WIDTH  HI register: product upper half, or remainder.
- lo_out  out  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While reset is low: state=IDLE, counter=0, all outputs 0. This applies immediately, including mid-operation; the in-flight result is discarded.
- States and transitions:
  - IDLE: accepts a start.
  - MULT and DIV: iterate.
  - FIX: sign fixup and HI/LO write, then return to IDLE.
- busy=1 in MULT, DIV and FIX; busy=0 in IDLE.
- Accept (edge k, state IDLE), for start_mult or start_div:
  - Capture operand magnitudes |a|, |b| and the result signs; clear the iterator.
  - Clear div_zero; done=0.
- Both starts high together: multiply wins and start_div is ignored.
- Starts while busy are ignored; no queueing.
- Iteration timing:
  - Edges k+1..k+WIDTH perform one iteration each.
  - The counter runs 0..WIDTH-1, and the last iteration moves the state to FIX.
- Edge k+WIDTH+1 (FIX): hi/lo are written, done<=1 for exactly one cycle, state returns to IDLE. A start may be accepted on the edge after done.
- Multiply:
  - 2·WIDTH-bit product of the magnitudes, negated if the operand signs differ.
  - {hi,lo} = full signed product.
- Divide:
  - Restoring division on the magnitudes.
  - Quotient truncates toward zero and is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
  - Overflow case −2^(WIDTH−1) / −1: lo = 0x80000000 (wraps), hi = 0; no flag.
- Divide by zero (start_div with b_in==0 at edge k):
  - No iteration; state stays IDLE.
  - done=1 and div_zero=1 in the cycle after edge k.
  - hi/lo are unchanged.
- div_zero stays high until the next accepted start.
- hi_out/lo_out hold their value until the next completing operation.

Optional Feature:
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined:
  - Adds an input port is_unsigned (1 bit), sampled on the accepting edge.
  - When is_unsigned=1, operands are treated as unsigned (multu/divu): no magnitude conversion, no fixup negation, and no overflow special case.
  - Latency is unchanged.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package mult_div_pkg:
  - State enum (IDLE, MULT, DIV, FIX).
  - WIDTH default.
  - Counter width constant, $clog2(WIDTH).
- Sub-module md_iter_unit: holds the 2·WIDTH-bit accumulator/remainder shift register and performs one shift-add or one restore-subtract step per enable.
- The top level keeps the FSM, counter, sign bookkeeping and HI/LO registers.

Test Plan:
- Multiply: a=7, b=0xFFFFFFFD (−3), start_mult at edge k.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - done pulses after edge k+33; busy is high during k..k+33.
- Divide: 100/7 gives lo=14, hi=2. Then 0xFFFFFFF9 (−7)/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: hi/lo preloaded by a prior op; start_div with b=0.
  - done and div_zero high the next cycle; busy never rises; hi/lo unchanged.
  - The next start clears div_zero.
- Overflow divide: 0x80000000 / 0xFFFFFFFF.
  - lo=0x80000000, hi=0, div_zero=0.
- Reset and restart: reset low mid-MULT (iteration 10).
  - busy, hi, lo and done go to 0 immediately; no done pulse follows.
  - After reset is released, 3×4 gives lo=12, hi=0 at the normal latency.
- Start contention:
  - start_mult and start_div asserted together: a multiply is performed.
  - start_div pulsed while busy: ignored; exactly one done pulse occurs.
